// File: rtl/dmem_port_arbiter.sv
// Data-memory port controller: CPU/debug arbitration, store byte lanes, load alignment.
// Debug port, starve counter and DBG_LD state exist only with DMEM_PORT_ARBITER_DEBUG_EN.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_halt,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_misalign,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-3:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StCpuLd, StDbgLd} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_uns_q, ld_uns_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        ld_mis_q, ld_mis_d;

  logic        dbg_win, cpu_win, cpu_mis;
  logic [1:0]  size_eff;
  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign size_eff = (cpu_size == 2'b11) ? 2'b10 : cpu_size;
  assign cpu_mis  = ((size_eff == 2'b01) && cpu_addr[0]) ||
                    ((size_eff == 2'b10) && (cpu_addr[1:0] != 2'b00));

  // Wins are gated by reset_n so every output reads 0 while reset is held.
`ifdef DMEM_PORT_ARBITER_DEBUG_EN
  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;
  logic            starved;

  assign starved = (starve_q == CntW'(STARVE_MAX));
  assign dbg_win = reset_n && (state_q == StIdle) && dbg_valid &&
                   (cpu_halt || !cpu_req || starved);

  always_comb begin
    starve_d = starve_q;
    if (dbg_valid && dbg_ready) begin
      starve_d = '0;
    end else if (dbg_valid && !starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_valid, dbg_we, dbg_addr, dbg_wdata};
  assign dbg_win    = 1'b0;
`endif

  assign cpu_win = reset_n && (state_q == StIdle) && !dbg_win && cpu_req && !cpu_halt;

  always_comb begin
    unique case (size_eff)
      2'b00: begin
        store_be   = 4'b0001 << cpu_addr[1:0];
        store_data = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        store_be   = cpu_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{cpu_wdata[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = cpu_wdata;
      end
    endcase
  end

  assign lane_b = mem_rdata[{ld_off_q, 3'b000} +: 8];
  assign lane_h = mem_rdata[{ld_off_q[1], 4'b0000} +: 16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ld_size_q <= 2'b00;
      ld_uns_q  <= 1'b0;
      ld_off_q  <= 2'b00;
      ld_mis_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      ld_off_q  <= ld_off_d;
      ld_mis_q  <= ld_mis_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    ld_off_d  = ld_off_q;
    ld_mis_d  = ld_mis_q;
    unique case (state_q)
      StIdle: begin
`ifdef DMEM_PORT_ARBITER_DEBUG_EN
        if (dbg_win && !dbg_we) begin
          state_d = StDbgLd;
        end
`endif
        // A misaligned load still passes through CPU_LD, returning 0.
        if (cpu_win && !cpu_we) begin
          state_d   = StCpuLd;
          ld_size_d = size_eff;
          ld_uns_d  = cpu_unsigned;
          ld_off_d  = cpu_addr[1:0];
          ld_mis_d  = cpu_mis;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_stall    = 1'b0;
    cpu_rdata    = '0;
    cpu_misalign = 1'b0;
    dbg_ready    = 1'b0;
    dbg_rvalid   = 1'b0;
    dbg_rdata    = '0;
    mem_en       = 1'b0;
    mem_we       = 4'b0000;
    mem_addr     = '0;
    mem_wdata    = '0;
    unique case (state_q)
      StIdle: begin
`ifdef DMEM_PORT_ARBITER_DEBUG_EN
        if (dbg_win) begin
          dbg_ready = 1'b1;
          mem_en    = 1'b1;
          mem_addr  = dbg_addr;
          cpu_stall = cpu_req;
          if (dbg_we) begin
            mem_we    = 4'b1111;
            mem_wdata = dbg_wdata;
          end
        end
`endif
        if (cpu_win) begin
          if (cpu_mis) begin
            cpu_misalign = 1'b1;
          end else begin
            mem_en   = 1'b1;
            mem_addr = cpu_addr[ADDR_W-1:2];
            if (cpu_we) begin
              mem_we    = store_be;
              mem_wdata = store_data;
            end else begin
              cpu_stall = 1'b1;
            end
          end
        end
      end
      StCpuLd: begin
        if (!ld_mis_q) begin
          unique case (ld_size_q)
            2'b00:   cpu_rdata = {{24{!ld_uns_q && lane_b[7]}}, lane_b};
            2'b01:   cpu_rdata = {{16{!ld_uns_q && lane_h[15]}}, lane_h};
            default: cpu_rdata = mem_rdata;
          endcase
        end
      end
`ifdef DMEM_PORT_ARBITER_DEBUG_EN
      StDbgLd: begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = mem_rdata;
        cpu_stall  = cpu_req;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboarded bench for dmem_port_arbiter: a byte-addressed reference model queues the
// expected outputs for each cycle and a monitor compares them against the DUT.
module tb_dmem_port_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned SM = 4;
`ifdef DMEM_PORT_ARBITER_DEBUG_EN
  localparam bit DbgEn = 1'b1;
`else
  localparam bit DbgEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, cpu_unsigned, cpu_halt;
  logic [1:0]    cpu_size;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_stall, cpu_misalign;
  logic [31:0]   cpu_rdata;
  logic          dbg_valid, dbg_ready, dbg_we, dbg_rvalid;
  logic [AW-3:0] dbg_addr;
  logic [31:0]   dbg_wdata, dbg_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  dmem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_halt(cpu_halt),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_misalign(cpu_misalign),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory seen by the DUT.
  logic [31:0] sram [1 << (AW - 2)];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_we[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        mis;
    logic [31:0] rdata;
    logic        rdy;
    logic        rv;
    logic [31:0] drdata;
    logic        en;
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: 0 idle, 1 CPU load result due, 2 debug read result due.
  logic [7:0]  mm [1 << AW];
  int          ph = 0;
  int          cnt = 0;
  logic [31:0] pend_val = '0;
  bit          last_stall = 1'b0;
  bit          last_rdy = 1'b0;

  task automatic model_step(output exp_t e);
    bit dw, cw;
    int nb, a, base;
    logic [63:0] v;
    e = '0;
    if (!reset_n) begin
      e.rst = 1'b1;
      ph    = 0;
      cnt   = 0;
    end else begin
      case (ph)
        0: begin
          dw = DbgEn && dbg_valid && (cpu_halt || !cpu_req || cnt == SM);
          cw = !dw && cpu_req && !cpu_halt;
          if (dw) begin
            base    = int'(dbg_addr) * 4;
            e.rdy   = 1'b1;
            e.en    = 1'b1;
            e.addr  = dbg_addr;
            e.stall = cpu_req;
            if (dbg_we) begin
              e.we    = 4'hf;
              e.wdata = dbg_wdata;
              for (int i = 0; i < 4; i++) mm[base + i] = dbg_wdata[8*i +: 8];
            end else begin
              for (int i = 0; i < 4; i++) pend_val[8*i +: 8] = mm[base + i];
              ph = 2;
            end
          end else if (cw) begin
            nb = (cpu_size == 2'd3) ? 4 : (1 << cpu_size);
            a  = int'(cpu_addr);
            if (a % nb != 0) begin
              e.mis = 1'b1;
              if (!cpu_we) begin
                pend_val = '0;
                ph       = 1;
              end
            end else if (cpu_we) begin
              e.en    = 1'b1;
              e.addr  = 10'(a / 4);
              e.we    = 4'(((1 << nb) - 1) << (a % 4));
              e.wdata = (nb == 1) ? 32'(cpu_wdata[7:0]) * 32'h01010101 :
                        (nb == 2) ? 32'(cpu_wdata[15:0]) * 32'h00010001 : cpu_wdata;
              for (int i = 0; i < nb; i++) mm[a + i] = cpu_wdata[8*i +: 8];
            end else begin
              e.en    = 1'b1;
              e.addr  = 10'(a / 4);
              e.stall = 1'b1;
              v = '0;
              for (int i = nb - 1; i >= 0; i--) v = (v << 8) | 64'(mm[a + i]);
              if (!cpu_unsigned && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
              pend_val = v[31:0];
              ph       = 1;
            end
          end
        end
        1: begin
          e.rdata = pend_val;
          ph      = 0;
        end
        default: begin
          e.rv     = 1'b1;
          e.drdata = pend_val;
          e.stall  = cpu_req;
          ph       = 0;
        end
      endcase
      if (DbgEn && dbg_valid) begin
        if (e.rdy) cnt = 0;
        else if (cnt < SM) cnt++;
      end
    end
  endtask

  // Called on a falling edge with inputs already driven; returns on the next falling edge.
  task automatic step();
    exp_t e;
    model_step(e);
    q.push_back(e);
    last_stall = e.stall;
    last_rdy   = e.rdy;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
        chk("cpu_misalign", 32'(cpu_misalign), 32'(e.mis));
        chk("cpu_rdata", cpu_rdata, e.rdata);
        chk("dbg_ready", 32'(dbg_ready), 32'(e.rdy));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e.rv));
        chk("mem_en", 32'(mem_en), 32'(e.en));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.rv || e.rst) chk("dbg_rdata", dbg_rdata, e.drdata);
        if (e.en || e.rst) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we != 4'b0000 || e.rst) chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
  end

  task automatic cpu_op(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [AW-1:0] a, input logic [31:0] wd);
    int n = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_unsigned = uns;
    cpu_addr = a; cpu_wdata = wd;
    do begin
      step();
      n++;
    end while ((last_stall || ph != 0) && n < 8);
    cpu_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << (AW - 2)); i++) sram[i] = '0;
    for (int i = 0; i < (1 << AW); i++) mm[i] = '0;
    reset_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_unsigned = 0; cpu_addr = '0;
    cpu_wdata = '0; cpu_halt = 0;
    dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    @(negedge clk);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Byte, half and misaligned-word accesses.
    cpu_op(1, 2'd0, 0, 12'h003, 32'h000000ff);
    cpu_op(0, 2'd0, 0, 12'h003, '0);
    cpu_op(0, 2'd0, 1, 12'h003, '0);
    cpu_op(1, 2'd1, 0, 12'h006, 32'h0000cfc7);
    cpu_op(0, 2'd1, 0, 12'h006, '0);
    cpu_op(0, 2'd1, 1, 12'h006, '0);
    cpu_op(0, 2'd2, 0, 12'h009, '0);
    cpu_op(1, 2'd2, 0, 12'h00a, 32'hdeadbeef);
    cpu_op(0, 2'd2, 0, 12'h008, '0);
    cpu_op(0, 2'd3, 0, 12'h004, '0);

    // Starvation: debug read of word 2 against back-to-back CPU stores.
    cpu_op(1, 2'd2, 0, 12'h008, 32'h12345678);
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd2;
    for (int k = 0; k < 9; k++) begin
      if (!last_stall) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd2;
        cpu_addr = 12'(12'h040 + 4 * k); cpu_wdata = $urandom();
      end
      if (last_rdy) dbg_valid = 1'b0;
      step();
    end
    cpu_req = 1'b0; dbg_valid = 1'b0;
    step();

    // Halt gives debug priority in the same cycle.
    cpu_halt = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h008; cpu_size = 2'd2;
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd3;
    step();
    dbg_valid = 1'b0;
    step();
    cpu_halt = 1'b0; cpu_req = 1'b0;
    step();

    // Reset while a debug read is in flight.
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd2;
    step();
    dbg_valid = 1'b0; reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    for (int k = 0; k < 3000; k++) begin
      if (!last_stall) begin
        cpu_req      = ($urandom_range(0, 9) < 7);
        cpu_we       = 1'($urandom_range(0, 1));
        cpu_size     = 2'($urandom_range(0, 3));
        cpu_unsigned = 1'($urandom_range(0, 1));
        cpu_addr     = 12'($urandom_range(0, 63));
        cpu_wdata    = $urandom();
        cpu_halt     = ($urandom_range(0, 9) == 0);
      end
      if (!dbg_valid || last_rdy) begin
        dbg_valid = ($urandom_range(0, 9) < 3);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 10'($urandom_range(0, 15));
        dbg_wdata = $urandom();
      end
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end

    reset_n = 1'b1; cpu_req = 1'b0; dbg_valid = 1'b0; cpu_halt = 1'b0;
    step();
    #5;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
